// File: rtl/sev_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan controller:
// blanking values, scan state encoding and the active-low hex glyph table.
package sev_seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] DIG_OFF = 8'hFF;

    typedef logic [0:0] scan_state_t;
    localparam scan_state_t BLANK = 1'b0;
    localparam scan_state_t DRIVE = 1'b1;

    // Segment order g..a, 0 = lit; entry [15] is 'F', entry [0] is '0'.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/sev_seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module sev_seg_hex_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Scan scheduler for a multiplexed seven-segment display: blank/drive slots per
// digit, registered outputs, and a shadow image that is applied only at frame ends.
module sev_seg_scan_ctrl
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 16384,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_dp,
    input  logic [7:0]  load_mask,
    output logic [7:0]  sev_seg_leds,
    output logic [7:0]  digit_en_n,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic [31:0] active_data;
    logic [7:0]  active_dp;
    logic [7:0]  active_mask;
    logic [31:0] shadow_data;
    logic [7:0]  shadow_dp;
    logic [7:0]  shadow_mask;
    logic        shadow_full;

    logic        slot_end;
    logic        frame_end;
    logic        accept;
    logic [6:0]  glyph;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_end  = slot_end && (idx == IDX_LAST);
    assign frame_done = frame_end;
    assign load_ready = ~shadow_full;
    assign accept     = load_valid && ~shadow_full;

    sev_seg_hex_decode u_decode (
        .nibble (active_data[{idx, 2'b00} +: 4]),
        .seg    (glyph)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= 3'd0;
        end else if (slot_end) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == BLANK_LAST) begin
                state <= DRIVE;
            end
        end
    end

    // Accept and transfer are exclusive: a full shadow never accepts a new load.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_full <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            shadow_mask <= '0;
            active_data <= '0;
            active_dp   <= '0;
            active_mask <= '0;
        end else if (accept) begin
            shadow_full <= 1'b1;
            shadow_data <= load_data;
            shadow_dp   <= load_dp;
            shadow_mask <= load_mask;
        end else if (frame_end && shadow_full) begin
            shadow_full <= 1'b0;
            active_data <= shadow_data;
            active_dp   <= shadow_dp;
            active_mask <= shadow_mask;
        end
    end

    // A masked digit keeps the segment bus dark as well as its anode off.
    always_ff @(posedge clk) begin
        if (reset) begin
            sev_seg_leds <= SEG_OFF;
            digit_en_n   <= DIG_OFF;
        end else if (state == DRIVE && active_mask[idx]) begin
            sev_seg_leds <= {~active_dp[idx], glyph};
            digit_en_n   <= ~(8'h01 << idx);
        end else begin
            sev_seg_leds <= SEG_OFF;
            digit_en_n   <= DIG_OFF;
        end
    end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed self-checking bench for sev_seg_scan_ctrl with 16-cycle slots,
// 4 blank cycles and 8 digits (128-cycle frames).
module tb_sev_seg_scan_ctrl;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [7:0]  load_dp;
    logic [7:0]  load_mask;
    logic [7:0]  sev_seg_leds;
    logic [7:0]  digit_en_n;
    logic        frame_done;

    int checks;
    int failures;
    int cyc;

    sev_seg_scan_ctrl #(
        .NUM_DIGITS   (8),
        .SLOT_CYCLES  (16),
        .BLANK_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_dp      (load_dp),
        .load_mask    (load_mask),
        .sev_seg_leds (sev_seg_leds),
        .digit_en_n   (digit_en_n),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic drive_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
        load_data  = d;
        load_dp    = dp;
        load_mask  = m;
        load_valid = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL reset_seg got=%h exp=FF", sev_seg_leds); end
        if (digit_en_n !== 8'hFF) begin failures++; $display("[TB] FAIL reset_dig got=%h exp=FF", digit_en_n); end
        if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_fd got=%b exp=0", frame_done); end
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", load_ready); end
    endtask

    task automatic test_idle();
        logic exp_fd;
        do_reset();
        for (int k = 0; k < 256; k++) begin
            exp_fd = ((cyc % 128) == 127);
            checks += 3;
            if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL idle_seg cyc=%0d got=%h exp=FF", cyc, sev_seg_leds); end
            if (digit_en_n !== 8'hFF) begin failures++; $display("[TB] FAIL idle_dig cyc=%0d got=%h exp=FF", cyc, digit_en_n); end
            if (frame_done !== exp_fd) begin failures++; $display("[TB] FAIL idle_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
            step();
        end
    endtask

    task automatic test_load_basic();
        logic [7:0] exp_seg;
        logic [7:0] exp_dig;
        do_reset();
        drive_load(32'h76543210, 8'h01, 8'hFF);
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready0 got=%b exp=1", load_ready); end
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready1 got=%b exp=0", load_ready); end
        run_to(126);
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_fd126 got=%b exp=0", frame_done); end
        run_to(127);
        checks += 2;
        if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL basic_fd127 got=%b exp=1", frame_done); end
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL basic_ready127 got=%b exp=0", load_ready); end
        run_to(128);
        checks += 3;
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready128 got=%b exp=1", load_ready); end
        if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL basic_fd128 got=%b exp=0", frame_done); end
        if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL basic_seg128 got=%h exp=FF", sev_seg_leds); end
        for (int k = 129; k <= 160; k++) begin
            step();
            if (k >= 133 && k <= 144) begin
                exp_dig = 8'hFE; exp_seg = 8'h40;
            end else if (k >= 149) begin
                exp_dig = 8'hFD; exp_seg = 8'hF9;
            end else begin
                exp_dig = 8'hFF; exp_seg = 8'hFF;
            end
            checks += 2;
            if (digit_en_n !== exp_dig) begin failures++; $display("[TB] FAIL basic_dig cyc=%0d got=%h exp=%h", cyc, digit_en_n, exp_dig); end
            if (sev_seg_leds !== exp_seg) begin failures++; $display("[TB] FAIL basic_seg cyc=%0d got=%h exp=%h", cyc, sev_seg_leds, exp_seg); end
        end
    endtask

    task automatic test_mask();
        int   p;
        logic lit;
        logic exp_fd;
        do_reset();
        drive_load(32'h76543210, 8'h00, 8'b0000_0100);
        step();
        load_valid = 1'b0;
        run_to(128);
        for (int k = 129; k <= 384; k++) begin
            step();
            p      = cyc - 1;
            lit    = ((p % 16) >= 4) && (((p / 16) % 8) == 2);
            exp_fd = ((cyc % 128) == 127);
            checks += 3;
            if (digit_en_n !== (lit ? 8'hFB : 8'hFF)) begin failures++; $display("[TB] FAIL mask_dig cyc=%0d got=%h exp=%h", cyc, digit_en_n, lit ? 8'hFB : 8'hFF); end
            if (sev_seg_leds !== (lit ? 8'hA4 : 8'hFF)) begin failures++; $display("[TB] FAIL mask_seg cyc=%0d got=%h exp=%h", cyc, sev_seg_leds, lit ? 8'hA4 : 8'hFF); end
            if (frame_done !== exp_fd) begin failures++; $display("[TB] FAIL mask_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
        end
    endtask

    task automatic test_held_load();
        do_reset();
        drive_load(32'h76543210, 8'h01, 8'hFF);
        step();
        drive_load(32'hFEDCBA98, 8'h02, 8'h03);
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL held_ready1 got=%b exp=0", load_ready); end
        run_to(127);
        checks += 2;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL held_ready127 got=%b exp=0", load_ready); end
        if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL held_fd127 got=%b exp=1", frame_done); end
        step();
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL held_ready128 got=%b exp=1", load_ready); end
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL held_ready129 got=%b exp=0", load_ready); end
        run_to(133);
        checks += 2;
        if (digit_en_n !== 8'hFE) begin failures++; $display("[TB] FAIL held_a_d0_dig got=%h exp=FE", digit_en_n); end
        if (sev_seg_leds !== 8'h40) begin failures++; $display("[TB] FAIL held_a_d0_seg got=%h exp=40", sev_seg_leds); end
        run_to(149);
        checks += 2;
        if (digit_en_n !== 8'hFD) begin failures++; $display("[TB] FAIL held_a_d1_dig got=%h exp=FD", digit_en_n); end
        if (sev_seg_leds !== 8'hF9) begin failures++; $display("[TB] FAIL held_a_d1_seg got=%h exp=F9", sev_seg_leds); end
        run_to(255);
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL held_ready255 got=%b exp=0", load_ready); end
        run_to(257);
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL held_ready257 got=%b exp=1", load_ready); end
        run_to(261);
        checks += 2;
        if (digit_en_n !== 8'hFE) begin failures++; $display("[TB] FAIL held_b_d0_dig got=%h exp=FE", digit_en_n); end
        if (sev_seg_leds !== 8'h80) begin failures++; $display("[TB] FAIL held_b_d0_seg got=%h exp=80", sev_seg_leds); end
        run_to(277);
        checks += 2;
        if (digit_en_n !== 8'hFD) begin failures++; $display("[TB] FAIL held_b_d1_dig got=%h exp=FD", digit_en_n); end
        if (sev_seg_leds !== 8'h10) begin failures++; $display("[TB] FAIL held_b_d1_seg got=%h exp=10", sev_seg_leds); end
        run_to(293);
        checks += 2;
        if (digit_en_n !== 8'hFF) begin failures++; $display("[TB] FAIL held_b_d2_dig got=%h exp=FF", digit_en_n); end
        if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL held_b_d2_seg got=%h exp=FF", sev_seg_leds); end
    endtask

    task automatic test_load_on_boundary();
        do_reset();
        run_to(127);
        checks += 2;
        if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL bnd_fd127 got=%b exp=1", frame_done); end
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL bnd_ready127 got=%b exp=1", load_ready); end
        drive_load(32'h00000005, 8'h00, 8'h01);
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL bnd_ready128 got=%b exp=0", load_ready); end
        run_to(133);
        checks += 2;
        if (digit_en_n !== 8'hFF) begin failures++; $display("[TB] FAIL bnd_early_dig got=%h exp=FF", digit_en_n); end
        if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL bnd_early_seg got=%h exp=FF", sev_seg_leds); end
        run_to(255);
        checks += 2;
        if (frame_done !== 1'b1) begin failures++; $display("[TB] FAIL bnd_fd255 got=%b exp=1", frame_done); end
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL bnd_ready255 got=%b exp=0", load_ready); end
        run_to(256);
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL bnd_ready256 got=%b exp=1", load_ready); end
        run_to(261);
        checks += 2;
        if (digit_en_n !== 8'hFE) begin failures++; $display("[TB] FAIL bnd_late_dig got=%h exp=FE", digit_en_n); end
        if (sev_seg_leds !== 8'h92) begin failures++; $display("[TB] FAIL bnd_late_seg got=%h exp=92", sev_seg_leds); end
    endtask

    task automatic test_reset_mid();
        logic exp_fd;
        do_reset();
        drive_load(32'h76543210, 8'h01, 8'hFF);
        step();
        load_valid = 1'b0;
        run_to(200);
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_ready200 got=%b exp=1", load_ready); end
        drive_load(32'h11111111, 8'hFF, 8'hFF);
        step();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid_ready201 got=%b exp=0", load_ready); end
        run_to(215);
        checks += 2;
        if (digit_en_n !== 8'hDF) begin failures++; $display("[TB] FAIL rmid_d5_dig got=%h exp=DF", digit_en_n); end
        if (sev_seg_leds !== 8'h92) begin failures++; $display("[TB] FAIL rmid_d5_seg got=%h exp=92", sev_seg_leds); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc   = 0;
        checks += 4;
        if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL rmid_seg got=%h exp=FF", sev_seg_leds); end
        if (digit_en_n !== 8'hFF) begin failures++; $display("[TB] FAIL rmid_dig got=%h exp=FF", digit_en_n); end
        if (load_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmid_ready got=%b exp=1", load_ready); end
        if (frame_done !== 1'b0) begin failures++; $display("[TB] FAIL rmid_fd got=%b exp=0", frame_done); end
        for (int k = 1; k <= 300; k++) begin
            step();
            exp_fd = ((cyc % 128) == 127);
            checks += 3;
            if (sev_seg_leds !== 8'hFF) begin failures++; $display("[TB] FAIL rmid_dark_seg cyc=%0d got=%h exp=FF", cyc, sev_seg_leds); end
            if (digit_en_n !== 8'hFF) begin failures++; $display("[TB] FAIL rmid_dark_dig cyc=%0d got=%h exp=FF", cyc, digit_en_n); end
            if (frame_done !== exp_fd) begin failures++; $display("[TB] FAIL rmid_fd cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_dp    = '0;
        load_mask  = '0;
        test_reset();
        test_idle();
        test_load_basic();
        test_mask();
        test_held_load();
        test_load_on_boundary();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sev_seg_scan_ctrl.md
Name: sev_seg_scan_ctrl

Overview:
- Scan scheduler for the 8-digit multiplexed seven-segment display.
- Time-shares the common segment bus among the digits using an internal prescaler, so no derived clock is needed.
- Inserts a blanking gap between digits to suppress ghosting.
- Accepts new display contents over a valid/ready handshake into a shadow buffer. The shadow buffer is applied only at a frame boundary, so a digit never tears mid-frame.

Parameters:
- NUM_DIGITS, 8: digits scanned per frame (1..8).
- SLOT_CYCLES, 16384: clk cycles per digit slot (blank + drive); must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 64: cycles at the start of each slot with all digits off.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  requester presents a new display image
- load_ready  output  1  shadow buffer empty; load accepted when load_valid && load_ready
- load_data  input  32  eight hex nibbles; nibble i drives digit i
- load_dp  input  8  decimal point per digit, 1 = lit
- load_mask  input  8  digit enable per digit, 1 = shown
- sev_seg_leds  output  8  segments, active-low; [6:0] = g..a, [7] = dp
- digit_en_n  output  8  digit anodes, active-low; bits at index NUM_DIGITS and above are held 1
- frame_done  output  1  one-cycle pulse at the end of the last digit's slot

Behaviour:
- Clock and reset: single clock domain, all state on posedge clk. Reset is synchronous, active-high, and wins over every other event.
- Reset values:
  - sev_seg_leds = 8'hFF, digit_en_n = 8'hFF, frame_done = 0, load_ready = 1.
  - Active data, dp and mask = 0; display is dark until the first load is applied.
  - Shadow buffer empty; digit index = 0; slot counter = 0; state = BLANK.
- State machine: two states, BLANK and DRIVE. The slot counter counts 0..SLOT_CYCLES-1.
  - BLANK: counter 0..BLANK_CYCLES-1. Outputs are all off (segments FF, anodes FF).
  - DRIVE: counter BLANK_CYCLES..SLOT_CYCLES-1. The anode for the current digit is low only if active_mask[idx] = 1. Segments show decode(active_data nibble idx) with dp = ~active_dp[idx]. A masked digit still consumes its full slot, so the refresh rate is constant and independent of the mask.
  - Slot end (counter = SLOT_CYCLES-1): counter goes to 0, state goes to BLANK, idx goes to idx+1. Idx wraps from NUM_DIGITS-1 to 0.
- Output timing: sev_seg_leds and digit_en_n are registered. They reflect the state and index of the previous cycle, a fixed 1-cycle lag that applies equally to blank and drive.
- Frame boundary: the slot end with idx = NUM_DIGITS-1.
  - frame_done = 1 for exactly that cycle.
  - If the shadow buffer is full, shadow data/dp/mask are copied to active on the same edge and the shadow is marked empty.
- Handshake:
  - load_ready = ~shadow_full.
  - On an accepting edge, load_data, load_dp and load_mask are captured into the shadow; load_ready falls on the next cycle.
  - load_ready rises on the cycle after the boundary that consumed the shadow.
  - The shadow is never overwritten while full; load_valid with ready = 0 is ignored and the requester holds.
- Simultaneous events:
  - A load accepted on a boundary cycle while the shadow is empty is stored in the shadow and applied at the next boundary. There is no bypass into the active registers.
  - A boundary cycle with the shadow full and load_valid high: the shadow transfers to active; the new load is not accepted that cycle because ready was 0.
- Reset mid-slot or mid-frame: the next edge returns everything to the reset values. Any pending shadow is discarded.
- Widths: the slot counter is $clog2(SLOT_CYCLES) bits and the index is 3 bits; no arithmetic overflow is possible beyond the wraps above.

Decomposition:
- Package sev_seg_pkg holds:
  - the 16-entry hex-to-segment constant table (active-low, 0 -> 7'h40 ... F -> 7'h0E);
  - SEG_OFF = 8'hFF and DIG_OFF = 8'hFF;
  - the state encoding typedef (BLANK, DRIVE).
- One combinational sub-module, sev_seg_hex_decode: 4-bit nibble in, 7-bit active-low segments out.

Test Plan (bench uses SLOT_CYCLES = 16, BLANK_CYCLES = 4, NUM_DIGITS = 8):
- Reset, no load: every cycle shows sev_seg_leds = FF and digit_en_n = FF; frame_done pulses every 128 cycles.
- Load data = 32'h76543210, dp = 8'h01, mask = 8'hFF:
  - load_ready falls the next cycle and rises the cycle after the first frame_done.
  - In the following frame, digit 0 drives anode 8'hFE with segments 8'h40 (7'h40, dp lit) for 12 cycles after 4 blank cycles.
  - Digit 1 drives 8'hFD with segments 8'hF9.
- Mask = 8'b0000_0100: only anode bit 2 ever goes low; the frame period stays 128 cycles.
- Second load while load_ready = 0: it is ignored, the first image is applied, and the held request is accepted after ready returns; verify both images in order.
- Load accepted exactly on a frame_done cycle: the new image appears one frame later, not immediately.
- Assert reset in the DRIVE phase of digit 5: outputs are FF the next cycle, the scan restarts at digit 0, the shadow is empty (load_ready = 1), and the display stays dark until a new load is applied.
